// File: rtl/fsm_multi_edge_detect_pkg.sv
// Shared types and constants for the multi-channel transition detector.
package fsm_edge_pkg;

  // INIT uses 2'b11 so that a cleared register is never mistaken for history.
  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_HIGH = 2'b01,
    ST_INIT = 2'b11
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/fsm_multi_edge_detect_chan.sv
// One channel: overlapping rise/fall FSM, registered flags, saturating event counter.
module edge_det_chan
  import fsm_edge_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             cnt_clr,
  output logic             det,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat,
  output logic             nxt_det
);

  state_t           r_state;
  logic             r_det, r_rise, r_fall, r_sat;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise_ev, w_fall_ev, w_det_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  // Events only exist on enabled edges, so en=0 forces all flags low.
  always_comb begin
    w_rise_ev = en & (r_state == ST_LOW)  &  ser_in;
    w_fall_ev = en & (r_state == ST_HIGH) & ~ser_in;
    w_det_nxt = (w_rise_ev & mode[0]) | (w_fall_ev & mode[1]);
    w_cnt_inc = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_det   <= 1'b0;
    end else begin
      r_rise <= w_rise_ev;
      r_fall <= w_fall_ev;
      r_det  <= w_det_nxt;
      if (en) begin
        case (r_state)
          ST_INIT, ST_LOW, ST_HIGH: r_state <= ser_in ? ST_HIGH : ST_LOW;
          default:                  r_state <= ST_INIT;
        endcase
      end
    end
  end

  // Clear wins over a coincident increment; the saturating count sets the sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_det_nxt && (r_cnt != '1)) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == '1) r_sat <= 1'b1;
    end
  end

  assign det     = r_det;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign cnt     = r_cnt;
  assign cnt_sat = r_sat;
  assign nxt_det = w_det_nxt;

endmodule

// File: rtl/fsm_multi_edge_detect.sv
// CH independent edge-detect channels sharing mode/enable/clear, plus a combined any_det flag.
module fsm_multi_edge_detect
  import fsm_edge_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [CH-1:0]       ser_in,
  input  logic                cnt_clr,
  output logic [CH-1:0]       det,
  output logic [CH-1:0]       rise,
  output logic [CH-1:0]       fall,
  output logic                any_det,
  output logic [CH*CNT_W-1:0] cnt,
  output logic [CH-1:0]       cnt_sat
);

  logic [CH-1:0] w_nxt_det;
  logic          r_any_det;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    edge_det_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .ser_in  (ser_in[g]),
      .cnt_clr (cnt_clr),
      .det     (det[g]),
      .rise    (rise[g]),
      .fall    (fall[g]),
      .cnt     (cnt[g*CNT_W +: CNT_W]),
      .cnt_sat (cnt_sat[g]),
      .nxt_det (w_nxt_det[g])
    );
  end

  // Built from next-state det so it lands on the same edge as det.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_any_det <= 1'b0;
    else      r_any_det <= |w_nxt_det;
  end

  assign any_det = r_any_det;

endmodule

// File: tb/tb_fsm_multi_edge_detect.sv
// Directed bench for fsm_multi_edge_detect; a second CNT_W=2 instance covers saturation.
module tb_fsm_multi_edge_detect;
  import fsm_edge_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, cnt_clr;
  logic [1:0]  mode;
  logic [3:0]  ser;
  logic [3:0]  det, rise, fall, cnt_sat;
  logic        any_det;
  logic [31:0] cnt;
  logic [3:0]  d2_det, d2_rise, d2_fall, d2_sat;
  logic        d2_any;
  logic [7:0]  d2_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_multi_edge_detect #(.CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ser_in(ser), .cnt_clr(cnt_clr),
    .det(det), .rise(rise), .fall(fall), .any_det(any_det), .cnt(cnt), .cnt_sat(cnt_sat)
  );

  fsm_multi_edge_detect #(.CH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ser_in(ser), .cnt_clr(cnt_clr),
    .det(d2_det), .rise(d2_rise), .fall(d2_fall), .any_det(d2_any), .cnt(d2_cnt), .cnt_sat(d2_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; mode = MODE_BOTH; ser = 4'b0000; cnt_clr = 1'b0;
    #12;
    checks++;
    if ({det, rise, fall, any_det, cnt_sat} !== 17'd0) begin
      errors++; $display("FAIL reset_flags: got %h exp 0", {det, rise, fall, any_det, cnt_sat});
    end
    checks++;
    if (cnt !== 32'd0 || d2_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h exp 0/0", cnt, d2_cnt);
    end
    rst = 1'b1; en = 1'b1;
  endtask

  task automatic test_both_overlap();
    int sv[6]  = '{0, 1, 0, 1, 1, 0};
    int ex[6]  = '{0, 1, 1, 1, 0, 1};
    mode = MODE_BOTH;
    for (int k = 0; k < 6; k++) begin
      ser[0] = sv[k][0];
      step();
      checks++;
      if (det[0] !== ex[k][0] || any_det !== ex[k][0]) begin
        errors++; $display("FAIL both_det step %0d: got det0=%b any=%b exp %0d", k, det[0], any_det, ex[k]);
      end
    end
    checks++;
    if (cnt[7:0] !== 8'd4) begin
      errors++; $display("FAIL both_cnt0: got %0d exp 4", cnt[7:0]);
    end
  endtask

  task automatic test_mode_select();
    int sv[4] = '{0, 1, 0, 1};
    int er[4] = '{0, 1, 0, 1};
    int ef[4] = '{0, 0, 1, 0};
    int ed[4] = '{0, 1, 0, 1};
    mode = MODE_RISE;
    for (int k = 0; k < 4; k++) begin
      ser[1] = sv[k][0];
      step();
      checks++;
      if (rise[1] !== er[k][0] || fall[1] !== ef[k][0] || det[1] !== ed[k][0]) begin
        errors++;
        $display("FAIL mode_rise step %0d: got r/f/d=%b%b%b exp %0d%0d%0d",
                 k, rise[1], fall[1], det[1], er[k], ef[k], ed[k]);
      end
    end
    mode = MODE_FALL;
    ser[1] = 1'b0;
    step();
    checks++;
    if (det[1] !== 1'b1 || fall[1] !== 1'b1) begin
      errors++; $display("FAIL mode_fall_switch: got det1=%b fall1=%b exp 1 1", det[1], fall[1]);
    end
  endtask

  task automatic test_saturate();
    int ec[6] = '{1, 2, 3, 3, 3, 3};
    int es[6] = '{0, 0, 1, 1, 1, 1};
    mode = MODE_BOTH;
    for (int k = 0; k < 6; k++) begin
      ser[2] = ~ser[2];
      step();
      checks++;
      if (d2_cnt[5:4] !== 2'(ec[k]) || d2_sat[2] !== es[k][0]) begin
        errors++; $display("FAIL sat_cnt step %0d: got cnt=%0d sat=%b exp %0d %0d", k, d2_cnt[5:4], d2_sat[2], ec[k], es[k]);
      end
    end
    cnt_clr = 1'b1;
    ser[2] = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (d2_det[2] !== 1'b1 || d2_cnt[5:4] !== 2'd0 || d2_sat[2] !== 1'b0) begin
      errors++; $display("FAIL sat_clr: got det=%b cnt=%0d sat=%b exp 1 0 0", d2_det[2], d2_cnt[5:4], d2_sat[2]);
    end
    checks++;
    if (cnt !== 32'd0) begin
      errors++; $display("FAIL clr_all: got %h exp 0", cnt);
    end
  endtask

  task automatic test_enable();
    ser[3] = 1'b0;
    step();
    step();
    checks++;
    if (det[3] !== 1'b0) begin
      errors++; $display("FAIL en_low_samples: got det3=%b exp 0", det[3]);
    end
    en = 1'b0;
    ser[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (det !== 4'd0 || rise !== 4'd0 || any_det !== 1'b0) begin
        errors++; $display("FAIL en_hold cyc %0d: got det=%b rise=%b any=%b exp 0", k, det, rise, any_det);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (det[3] !== 1'b1 || rise[3] !== 1'b1 || cnt[31:24] !== 8'd1) begin
      errors++; $display("FAIL en_resume: got det3=%b rise3=%b cnt3=%0d exp 1 1 1", det[3], rise[3], cnt[31:24]);
    end
  endtask

  task automatic test_reset_midstream();
    mode = MODE_BOTH;
    for (int k = 0; k < 5; k++) begin
      ser[0] = ~ser[0];
      step();
    end
    checks++;
    if (cnt[7:0] !== 8'd5 || det[0] !== 1'b1) begin
      errors++; $display("FAIL pre_rst: got cnt0=%0d det0=%b exp 5 1", cnt[7:0], det[0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (det !== 4'd0 || any_det !== 1'b0 || cnt !== 32'd0 || cnt_sat !== 4'd0 || rise !== 4'd0) begin
      errors++; $display("FAIL async_rst: got det=%b any=%b cnt=%h sat=%b exp 0", det, any_det, cnt, cnt_sat);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    ser[0] = 1'b0;
    step();
    checks++;
    if (det !== 4'd0) begin
      errors++; $display("FAIL post_rst_init: got det=%b exp 0000", det);
    end
    ser[0] = 1'b1;
    step();
    checks++;
    if (det !== 4'b0001 || cnt[7:0] !== 8'd1) begin
      errors++; $display("FAIL post_rst_rise: got det=%b cnt0=%0d exp 0001 1", det, cnt[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    mode = MODE_RISE;
    ser = 4'b0000;
    step();
    checks++;
    if (det !== 4'd0 || fall[0] !== 1'b1) begin
      errors++; $display("FAIL all_low: got det=%b fall0=%b exp 0000 1", det, fall[0]);
    end
    ser = 4'b1111;
    step();
    checks++;
    if (det !== 4'b1111 || any_det !== 1'b1 || rise !== 4'b1111) begin
      errors++; $display("FAIL all_rise: got det=%b any=%b rise=%b exp 1111 1 1111", det, any_det, rise);
    end
    checks++;
    if (cnt !== {8'd1, 8'd1, 8'd1, 8'd2}) begin
      errors++; $display("FAIL all_rise_cnt: got %h exp 01010102", cnt);
    end
    step();
    checks++;
    if (det !== 4'd0 || any_det !== 1'b0) begin
      errors++; $display("FAIL all_hold: got det=%b any=%b exp 0000 0", det, any_det);
    end
  endtask

  initial begin
    test_reset();
    test_both_overlap();
    test_mode_select();
    test_saturate();
    test_enable();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
